// File: rtl/v_fifo.sv
// v_fifo: parameterised synchronous FIFO with valid/ready handshakes on both
// sides. It buffers between producer and consumer pipeline stages, absorbs
// backpressure and reports its occupancy.
//
// Optional feature macro: V_FIFO_BYPASS_EN
//   When defined, an empty FIFO forwards in_data straight to out_data in the
//   same cycle. If the consumer takes it, nothing is written.
//   When undefined, the minimum latency is one cycle. out_vld and out_data
//   then depend only on registered state.
//
// Parameters:
//   W      data width in bits (>=1)
//   N      depth in entries (power of two, >=2)
//   LOG2N  pointer index width, derived from N
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   flush     discard every held entry, including a same-cycle push
//   in_vld    producer has data
//   in_data   producer payload
//   in_rdy    FIFO can accept (not full)
//   out_vld   FIFO has data for the consumer
//   out_data  head entry payload, zero when nothing is offered
//   out_rdy   consumer accepts
//   level     entries held, 0..N
//   empty     level == 0
//   full      level == N
module v_fifo #(
  parameter  int W     = 32,
  parameter  int N     = 4,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [W-1:0]     in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [W-1:0]     out_data,
  input  logic             out_rdy,
  output logic [LOG2N:0]   level,
  output logic             empty,
  output logic             full
);

  localparam logic [LOG2N:0] PTR_ONE = (LOG2N+1)'(1);

  // Storage is not reset. Entries are only readable between the pointers.
  logic [W-1:0]   r_mem [N];

  // Pointers carry one extra wrap bit. They count modulo 2N, so equal
  // pointers mean empty. Equal index bits with different wrap bits mean full.
  logic [LOG2N:0] r_wr_ptr;
  logic [LOG2N:0] r_rd_ptr;

  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_wr_en;
  logic           w_rd_en;
  logic [LOG2N:0] w_push_inc;
  logic [W-1:0]   w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[LOG2N-1:0] == r_rd_ptr[LOG2N-1:0]) &&
                   (r_wr_ptr[LOG2N] != r_rd_ptr[LOG2N]);

  // in_rdy depends only on registered pointers. It has no path from out_rdy.
  assign in_rdy  = ~w_full;
  assign w_push  = in_vld & in_rdy;
  assign w_pop   = out_vld & out_rdy;
  assign w_head  = w_empty ? '0 : r_mem[r_rd_ptr[LOG2N-1:0]];

`ifdef V_FIFO_BYPASS_EN
  logic w_bypass;

  // Empty FIFO with a fresh entry: offer it to the consumer directly.
  assign w_bypass = w_empty & in_vld & ~flush;
  assign out_vld  = ~w_empty | w_bypass;
  assign out_data = w_bypass ? in_data : w_head;
  // An entry consumed through the bypass is never stored.
  assign w_wr_en  = w_push & ~(w_bypass & out_rdy);
`else
  assign out_vld  = ~w_empty;
  assign out_data = w_head;
  assign w_wr_en  = w_push;
`endif

  // A pop only moves the read pointer when it took a stored entry.
  assign w_rd_en    = w_pop & ~w_empty;
  assign w_push_inc = {{LOG2N{1'b0}}, w_push};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      // A same-cycle push is also dropped: the read pointer jumps past it.
      // Any concurrent pop is ignored.
      r_wr_ptr <= r_wr_ptr + w_push_inc;
      r_rd_ptr <= r_wr_ptr + w_push_inc;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) begin
      r_mem[r_wr_ptr[LOG2N-1:0]] <= in_data;
    end
  end

  // The modulo-2N difference of the pointers is the occupancy, 0..N.
  assign level = r_wr_ptr - r_rd_ptr;
  assign empty = w_empty;
  assign full  = w_full;

  // The producer keeps an offered entry stable until it is taken.
  a_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (in_vld && !in_rdy) |=> (in_vld && $stable(in_data)));

  // An offered head entry stays put until popped, unless flushed.
  a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld && !out_rdy && !flush) |=> (out_vld && $stable(out_data)));

endmodule

// File: tb/tb_v_fifo.sv
// tb_v_fifo: directed and randomised checks of v_fifo against a queue-based
// reference model. Build with V_FIFO_BYPASS_EN defined to check the bypass
// variant.
module tb_v_fifo;

  localparam int W = 32;
  localparam int N = 4;
`ifdef V_FIFO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_vld;
  logic [W-1:0]  in_data;
  logic          in_rdy;
  logic          out_vld;
  logic [W-1:0]  out_data;
  logic          out_rdy;
  logic [2:0]    level;
  logic          empty;
  logic          full;

  int            checks   = 0;
  int            failures = 0;
  logic [31:0]   q[$];       // entries the FIFO should hold, head first
  logic [31:0]   popped[$];  // entries the consumer has taken, in order
  bit            last_push;

  always #5 clk = ~clk;

  v_fifo #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .level    (level),
    .empty    (empty),
    .full     (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs as currently driven. The task is entered
  // at a falling edge. It checks the outputs against the model, lets the
  // rising edge happen, updates the model and returns at the next falling
  // edge.
  task automatic cycle(input bit en);
    int          sz;
    bit          byp;
    logic        ev;
    logic [31:0] ed;
    bit          ep;
    bit          eo;
    sz  = q.size();
    byp = BYPASS && (sz == 0) && in_vld && !flush;
    ev  = (sz > 0) || byp;
    ed  = byp ? in_data : ((sz > 0) ? q[0] : 32'h0);
    #1;
    if (en) begin
      chk("out_vld",  32'(out_vld),  32'(ev));
      chk("out_data", out_data,      ed);
      chk("in_rdy",   32'(in_rdy),   32'(sz < N));
      chk("level",    32'(level),    32'(sz));
      chk("empty",    32'(empty),    32'(sz == 0));
      chk("full",     32'(full),     32'(sz == N));
    end
    ep = in_vld && (sz < N) && rst_n;
    eo = ev && out_rdy && rst_n && !flush;
    @(posedge clk);
    last_push = ep;
    if (!rst_n || flush) begin
      q.delete();
    end else if (byp && out_rdy) begin
      popped.push_back(in_data);
    end else begin
      if (eo) popped.push_back(q.pop_front());
      if (ep) q.push_back(in_data);
    end
    if (ep || eo)
      $display("t=%0t push=%0b pop=%0b in=%h out=%h flush=%0b level_after=%0d",
               $time, ep, eo, in_data, ed, flush, q.size());
    @(negedge clk);
  endtask

  initial begin
    int          nb;
    bit          hold;
    logic [31:0] exp_seq [5];
    exp_seq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0};

    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
    @(negedge clk);
    cycle(0);
    cycle(1);
    rst_n = 1'b1;
    chk("rst_in_rdy",   32'(in_rdy),  32'd1);
    chk("rst_out_vld",  32'(out_vld), 32'd0);
    chk("rst_level",    32'(level),   32'd0);
    chk("rst_empty",    32'(empty),   32'd1);
    chk("rst_full",     32'(full),    32'd0);
    chk("rst_out_data", out_data,     32'd0);

    // Fill to full, then hold off a fifth entry.
    in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + 32'(i);
      cycle(1);
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("fill_full",   32'(full),   32'd1);
    chk("fill_in_rdy", 32'(in_rdy), 32'd0);
    in_data = 32'hB0;
    cycle(1);
    chk("held_level", 32'(level), 32'd4);

    // Pop from full. in_rdy returns the next cycle, then steady push/pop.
    popped.delete();
    out_rdy = 1'b1;
    nb = 0;
    cycle(1);
    chk("pop_full_in_rdy", 32'(in_rdy), 32'd1);
    chk("pop_full_level",  32'(level),  32'd3);
    for (int k = 0; k < 7; k++) begin
      cycle(1);
      if (last_push) begin nb++; in_data = 32'hB0 + 32'(nb); end
    end
    chk("order_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 5; i++) chk("order_data", popped[i], exp_seq[i]);

    // Drain.
    in_vld = 1'b0;
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle(1);

    // Ten entries through the FIFO, wrapping the pointers.
    popped.delete();
    nb = 0; in_vld = 1'b1; in_data = 32'h10;
    for (int c = 0; c < 40 && nb < 10; c++) begin
      out_rdy = (c >= 2);
      cycle(1);
      if (last_push) begin
        nb++;
        in_data = 32'h10 + 32'(nb);
        if (nb == 10) in_vld = 1'b0;
      end
    end
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle(1);
    chk("wrap_count", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10; i++) chk("wrap_data", popped[i], 32'h10 + 32'(i));

    // Flush at level 3 with a same-cycle push of 0xC0.
    popped.delete();
    out_rdy = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 32'hE0 + 32'(i); cycle(1); end
    chk("pre_flush_level", 32'(level), 32'd3);
    flush = 1'b1; in_data = 32'hC0;
    cycle(1);
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_level",   32'(level),   32'd0);
    chk("flush_empty",   32'(empty),   32'd1);
    chk("flush_out_vld", 32'(out_vld), 32'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1);
    chk("flush_nothing_out", 32'(popped.size()), 32'd0);

    // Single entry into an empty FIFO with the consumer ready.
    in_vld = 1'b1; in_data = 32'hD0; out_rdy = 1'b1;
    #1;
    chk("byp_same_vld",  32'(out_vld), BYPASS ? 32'd1 : 32'd0);
    chk("byp_same_data", out_data,     BYPASS ? 32'hD0 : 32'h0);
    cycle(1);
    in_vld = 1'b0;
    #1;
    chk("byp_next_vld",   32'(out_vld), BYPASS ? 32'd0 : 32'd1);
    chk("byp_next_data",  out_data,     BYPASS ? 32'h0 : 32'hD0);
    chk("byp_next_level", 32'(level),   BYPASS ? 32'd0 : 32'd1);
    cycle(1);

    // Reset while holding entries.
    out_rdy = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 2; i++) begin in_data = 32'hF0 + 32'(i); cycle(1); end
    in_vld = 1'b0; rst_n = 1'b0; out_rdy = 1'b1;
    cycle(1);
    rst_n = 1'b1;
    chk("midrst_level",   32'(level),   32'd0);
    chk("midrst_out_vld", 32'(out_vld), 32'd0);

    // Random traffic. The producer holds an unaccepted entry.
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      out_rdy = $urandom_range(0, 1);
      if (!hold) begin
        in_vld  = $urandom_range(0, 1);
        in_data = $urandom;
      end
      cycle(1);
      hold = in_vld && !last_push && rst_n;
    end
    rst_n = 1'b1; flush = 1'b0; in_vld = 1'b0;
    cycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
